// File: rtl/temp_control_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : temp_control_fsm                                              |
// | Purpose  : Thermostat decision FSM with hysteresis, dwell, sensor-fault  |
// |            detection, sample watchdog and error recovery.                |
// | Options  : TEMP_CTRL_FILTER_EN - 4-sample moving mean on the temperature |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module temp_control_fsm #(
   parameter int unsigned TEMP_W          = 8,
   parameter int unsigned HYST            = 2,
   parameter int unsigned DWELL_CYCLES    = 8,
   parameter int unsigned TIMEOUT_CYCLES  = 20,
   parameter int unsigned RECOVER_SAMPLES = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              temp_valid,
   input  logic [TEMP_W-1:0] temp_value,
   input  logic [TEMP_W-1:0] setpoint,
   output logic [1:0]        status,
   output logic              heater_en,
   output logic              cooler_en
);

   localparam int c_EXT_W     = TEMP_W + 2;
   localparam int c_DWELL_W   = $clog2(DWELL_CYCLES + 1);
   localparam int c_TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int c_RECOVER_W = $clog2(RECOVER_SAMPLES + 1);

   localparam logic [c_EXT_W-1:0]     c_HYST_EXT   = c_EXT_W'(HYST);
   localparam logic [c_DWELL_W-1:0]   c_DWELL_MAX  = c_DWELL_W'(DWELL_CYCLES);
   localparam logic [c_TIMEOUT_W-1:0] c_TIMEOUT   = c_TIMEOUT_W'(TIMEOUT_CYCLES);
   localparam logic [c_RECOVER_W-1:0] c_REC_LAST  = c_RECOVER_W'(RECOVER_SAMPLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_HEAT  = 2'b01,
      ST_COOL  = 2'b10,
      ST_ERROR = 2'b11
   } state_t;

   state_t                 state_q, state_d;
   logic                   heater_en_q, cooler_en_q;
   logic [c_DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
   logic [c_TIMEOUT_W-1:0] timeout_cnt_q, timeout_cnt_d;
   logic [c_RECOVER_W-1:0] recover_cnt_q, recover_cnt_d;

   logic                   w_fault;
   logic                   w_timeout;
   logic                   w_dwell_done;
   logic [c_EXT_W-1:0]     w_t_ext;
   logic [c_EXT_W-1:0]     w_sp_ext;
   logic                   w_cold;
   logic                   w_hot;
   logic                   w_at_or_above;
   logic                   w_at_or_below;
   logic                   w_enter_error;

   // Fault detection always looks at the raw sensor word.
   assign w_fault      = temp_valid && ((temp_value == '0) || (temp_value == '1));
   assign w_timeout    = !temp_valid && (timeout_cnt_q == c_TIMEOUT);
   assign w_dwell_done = (dwell_cnt_q == c_DWELL_MAX);
   assign w_enter_error = (state_q != ST_ERROR) && (state_d == ST_ERROR);

`ifdef TEMP_CTRL_FILTER_EN
   logic [TEMP_W-1:0]  hist0_q, hist1_q, hist2_q;
   logic [TEMP_W-1:0]  hist0_d, hist1_d, hist2_d;
   logic               hist_vld_q, hist_vld_d;
   logic [c_EXT_W-1:0] w_sum;

   // An empty history behaves as if all four slots hold the current sample.
   always_comb begin
      if (hist_vld_q) begin
         w_sum = c_EXT_W'(temp_value) + c_EXT_W'(hist0_q)
               + c_EXT_W'(hist1_q) + c_EXT_W'(hist2_q);
      end else begin
         w_sum = {temp_value, 2'b00};
      end
   end

   assign w_t_ext = w_sum >> 2;

   always_comb begin
      hist0_d    = hist0_q;
      hist1_d    = hist1_q;
      hist2_d    = hist2_q;
      hist_vld_d = hist_vld_q;
      if (w_enter_error) begin
         hist_vld_d = 1'b0;
      end else if (temp_valid && !w_fault) begin
         hist_vld_d = 1'b1;
         if (hist_vld_q) begin
            hist0_d = temp_value;
            hist1_d = hist0_q;
            hist2_d = hist1_q;
         end else begin
            hist0_d = temp_value;
            hist1_d = temp_value;
            hist2_d = temp_value;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist0_q    <= '0;
         hist1_q    <= '0;
         hist2_q    <= '0;
         hist_vld_q <= 1'b0;
      end else begin
         hist0_q    <= hist0_d;
         hist1_q    <= hist1_d;
         hist2_q    <= hist2_d;
         hist_vld_q <= hist_vld_d;
      end
   end
`else
   assign w_t_ext = {2'b00, temp_value};
`endif

   // Two extra bits keep setpoint+HYST and t+HYST from wrapping.
   assign w_sp_ext      = {2'b00, setpoint};
   assign w_cold        = (w_t_ext + c_HYST_EXT) < w_sp_ext;
   assign w_hot         = w_t_ext > (w_sp_ext + c_HYST_EXT);
   assign w_at_or_above = w_t_ext >= w_sp_ext;
   assign w_at_or_below = w_t_ext <= w_sp_ext;

   always_comb begin
      state_d       = state_q;
      recover_cnt_d = recover_cnt_q;
      if ((state_q != ST_ERROR) && (w_fault || w_timeout)) begin
         state_d = ST_ERROR;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (temp_valid && w_dwell_done) begin
                  if (w_cold) begin
                     state_d = ST_HEAT;
                  end else if (w_hot) begin
                     state_d = ST_COOL;
                  end
               end
            end
            ST_HEAT: begin
               if (temp_valid && w_dwell_done && w_at_or_above) begin
                  state_d = ST_IDLE;
               end
            end
            ST_COOL: begin
               if (temp_valid && w_dwell_done && w_at_or_below) begin
                  state_d = ST_IDLE;
               end
            end
            ST_ERROR: begin
               if (temp_valid && !w_fault) begin
                  if (recover_cnt_q == c_REC_LAST) begin
                     state_d       = ST_IDLE;
                     recover_cnt_d = '0;
                  end else begin
                     recover_cnt_d = recover_cnt_q + c_RECOVER_W'(1);
                  end
               end else if (w_fault || w_timeout) begin
                  recover_cnt_d = '0;
               end
            end
            default: state_d = ST_ERROR;
         endcase
      end
   end

   always_comb begin
      dwell_cnt_d = dwell_cnt_q;
      if (state_d != state_q) begin
         dwell_cnt_d = '0;
      end else if (!w_dwell_done) begin
         dwell_cnt_d = dwell_cnt_q + c_DWELL_W'(1);
      end
   end

   always_comb begin
      timeout_cnt_d = timeout_cnt_q;
      if (temp_valid) begin
         timeout_cnt_d = '0;
      end else if (timeout_cnt_q != c_TIMEOUT) begin
         timeout_cnt_d = timeout_cnt_q + c_TIMEOUT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         heater_en_q   <= 1'b0;
         cooler_en_q   <= 1'b0;
         dwell_cnt_q   <= '0;
         timeout_cnt_q <= '0;
         recover_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         heater_en_q   <= (state_d == ST_HEAT);
         cooler_en_q   <= (state_d == ST_COOL);
         dwell_cnt_q   <= dwell_cnt_d;
         timeout_cnt_q <= timeout_cnt_d;
         recover_cnt_q <= recover_cnt_d;
      end
   end

   assign status    = state_q;
   assign heater_en = heater_en_q;
   assign cooler_en = cooler_en_q;

endmodule
`default_nettype wire

// File: tb/tb_temp_control_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_temp_control_fsm                                           |
// | Purpose  : Directed and randomized self-checking bench for the FSM.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_temp_control_fsm;

   localparam int HYST    = 2;
   localparam int DWELL   = 8;
   localparam int TIMEOUT = 20;
   localparam int RECOVER = 3;

   logic       clk;
   logic       rst_n;
   logic       temp_valid;
   logic [7:0] temp_value;
   logic [7:0] setpoint;
   logic [1:0] status;
   logic       heater_en;
   logic       cooler_en;

   int n_tests;
   int n_fail;

   logic [7:0] sp_r;

   // Reference model: mode plus elapsed-cycle bookkeeping in plain integers.
   int m_mode;          // 0 idle, 1 heat, 2 cool, 3 error
   int m_since_entry;
   int m_since_valid;
   int m_good_run;
   int m_hist[$];

   temp_control_fsm #(
      .TEMP_W(8), .HYST(HYST), .DWELL_CYCLES(DWELL),
      .TIMEOUT_CYCLES(TIMEOUT), .RECOVER_SAMPLES(RECOVER)
   ) dut (
      .clk(clk), .rst_n(rst_n), .temp_valid(temp_valid),
      .temp_value(temp_value), .setpoint(setpoint),
      .status(status), .heater_en(heater_en), .cooler_en(cooler_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_mode        = 0;
      m_since_entry = 0;
      m_since_valid = 0;
      m_good_run    = 0;
      m_hist.delete();
   endtask

   task automatic model_step(input bit v, input int temp, input int sp);
      bit fault;
      bit timed_out;
      bit dwell_ok;
      int t;
      int nxt;
      fault     = v && (temp == 0 || temp == 255);
      timed_out = !v && (m_since_valid >= TIMEOUT);
      dwell_ok  = (m_since_entry >= DWELL);
      t         = temp;
`ifdef TEMP_CTRL_FILTER_EN
      if (v && !fault) begin
         if (m_hist.size() == 0) repeat (4) m_hist.push_back(temp);
         else begin
            m_hist.push_back(temp);
            void'(m_hist.pop_front());
         end
         t = (m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3]) / 4;
      end
`endif
      nxt = m_mode;
      if (m_mode != 3 && (fault || timed_out)) nxt = 3;
      else if (m_mode == 0) begin
         if (v && dwell_ok && (t + HYST < sp)) nxt = 1;
         else if (v && dwell_ok && (t > sp + HYST)) nxt = 2;
      end else if (m_mode == 1) begin
         if (v && dwell_ok && t >= sp) nxt = 0;
      end else if (m_mode == 2) begin
         if (v && dwell_ok && t <= sp) nxt = 0;
      end else begin
         if (v && !fault) begin
            m_good_run++;
            if (m_good_run == RECOVER) begin
               nxt = 0;
               m_good_run = 0;
            end
         end else if (fault || timed_out) m_good_run = 0;
      end
`ifdef TEMP_CTRL_FILTER_EN
      if (nxt == 3 && m_mode != 3) m_hist.delete();
`endif
      m_since_entry = (nxt != m_mode) ? 0 : m_since_entry + 1;
      m_since_valid = v ? 0 : m_since_valid + 1;
      m_mode = nxt;
   endtask

   task automatic cyc(input bit v, input logic [7:0] t);
      @(negedge clk);
      temp_valid = v;
      temp_value = t;
      setpoint   = sp_r;
      @(posedge clk);
      model_step(v, int'(t), int'(sp_r));
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'd70);
   endtask

   task automatic release_reset();
      @(negedge clk);
      temp_valid = 1'b0;
      rst_n      = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      n_tests++;
      if ({status, heater_en, cooler_en} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_state got=%b expected=0000", {status, heater_en, cooler_en});
      end
      release_reset();
      idle(9);
      cyc(1'b1, 8'd67);
      n_tests++;
      if (status !== 2'b01 || heater_en !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_heat status=%0d heater=%0d expected 1/1", status, heater_en);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (status !== 2'b00 || heater_en !== 1'b0 || cooler_en !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset status=%0d heater=%0d cooler=%0d expected 0/0/0",
                  status, heater_en, cooler_en);
      end
      release_reset();
      idle(9);
      cyc(1'b1, 8'd70);
      n_tests++;
      if (status !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_then_70 status=%0d expected=0", status);
      end
   endtask

   task automatic test_heat();
      cyc(1'b1, 8'd67);
      n_tests++;
      if (status !== 2'b01 || heater_en !== 1'b1 || cooler_en !== 1'b0) begin
         n_fail++;
         $display("FAIL heat_entry status=%0d heater=%0d cooler=%0d expected 1/1/0",
                  status, heater_en, cooler_en);
      end
      idle(3);
      cyc(1'b1, 8'd69);
      n_tests++;
      if (status !== 2'b01) begin
         n_fail++;
         $display("FAIL heat_hold_69 status=%0d expected=1", status);
      end
      idle(5);
      cyc(1'b1, 8'd70);
      n_tests++;
      if (status !== 2'b00 || heater_en !== 1'b0) begin
         n_fail++;
         $display("FAIL heat_exit status=%0d heater=%0d expected 0/0", status, heater_en);
      end
   endtask

   task automatic test_dwell();
      idle(2);
      cyc(1'b1, 8'd80);
      n_tests++;
      if (status !== 2'b00) begin
         n_fail++;
         $display("FAIL dwell_early status=%0d expected=0", status);
      end
      idle(4);
      cyc(1'b1, 8'd80);
      n_tests++;
      if (status !== 2'b00) begin
         n_fail++;
         $display("FAIL dwell_boundary status=%0d expected=0", status);
      end
      cyc(1'b1, 8'd80);
      n_tests++;
      if (status !== 2'b10 || cooler_en !== 1'b1 || heater_en !== 1'b0) begin
         n_fail++;
         $display("FAIL cool_entry status=%0d cooler=%0d heater=%0d expected 2/1/0",
                  status, cooler_en, heater_en);
      end
   endtask

   task automatic test_timeout();
      logic [7:0] seq [6];
      logic [1:0] exp_st [6];
      seq    = '{8'd70, 8'd70, 8'hFF, 8'd70, 8'd70, 8'd70};
      exp_st = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
      idle(20);
      n_tests++;
      if (status !== 2'b10) begin
         n_fail++;
         $display("FAIL timeout_not_yet status=%0d expected=2", status);
      end
      idle(1);
      n_tests++;
      if (status !== 2'b11 || heater_en !== 1'b0 || cooler_en !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_error status=%0d heater=%0d cooler=%0d expected 3/0/0",
                  status, heater_en, cooler_en);
      end
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, seq[i]);
         n_tests++;
         if (status !== exp_st[i]) begin
            n_fail++;
            $display("FAIL recover_seq[%0d] status=%0d expected=%0d", i, status, exp_st[i]);
         end
      end
   endtask

   task automatic test_timeout_rescue();
      idle(20);
      cyc(1'b1, 8'd70);
      n_tests++;
      if (status !== 2'b00) begin
         n_fail++;
         $display("FAIL timeout_rescue status=%0d expected=0", status);
      end
      idle(20);
      n_tests++;
      if (status !== 2'b00) begin
         n_fail++;
         $display("FAIL timeout_restart status=%0d expected=0", status);
      end
      idle(1);
      n_tests++;
      if (status !== 2'b11) begin
         n_fail++;
         $display("FAIL timeout_second status=%0d expected=3", status);
      end
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'd72);
      n_tests++;
      if (status !== 2'b00) begin
         n_fail++;
         $display("FAIL timeout_recover status=%0d expected=0", status);
      end
   endtask

   task automatic test_fault();
      cyc(1'b1, 8'h00);
      n_tests++;
      if (status !== 2'b11) begin
         n_fail++;
         $display("FAIL fault_zero status=%0d expected=3", status);
      end
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'd70);
      idle(8);
      cyc(1'b1, 8'd60);
      n_tests++;
      if (status !== 2'b01) begin
         n_fail++;
         $display("FAIL fault_prep_heat status=%0d expected=1", status);
      end
      cyc(1'b1, 8'hFF);
      n_tests++;
      if (status !== 2'b11 || heater_en !== 1'b0) begin
         n_fail++;
         $display("FAIL fault_ones status=%0d heater=%0d expected 3/0", status, heater_en);
      end
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'd70);
   endtask

`ifdef TEMP_CTRL_FILTER_EN
   task automatic test_filter();
      logic [7:0] seq [5];
      logic [1:0] exp_st [5];
      seq    = '{8'd70, 8'd70, 8'd70, 8'd62, 8'd62};
      exp_st = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
      release_reset();
      idle(9);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, seq[i]);
         n_tests++;
         if (status !== exp_st[i]) begin
            n_fail++;
            $display("FAIL filter_seq[%0d] status=%0d expected=%0d", i, status, exp_st[i]);
         end
      end
   endtask
`endif

   task automatic test_random();
      logic [1:0] exp_st;
      int r;
      int v;
      for (int n = 0; n < 3000; n++) begin
         if (n % 150 == 0) begin
            r = $urandom_range(0, 5);
            case (r)
               0: sp_r = 8'd0;
               1: sp_r = 8'd255;
               2: sp_r = 8'd254;
               3: sp_r = 8'd1;
               default: sp_r = 8'($urandom_range(0, 255));
            endcase
         end
         if ($urandom_range(0, 199) == 0) begin
            for (int k = 0; k < int'($urandom_range(18, 24)); k++) cyc(1'b0, 8'd0);
         end
         r = $urandom_range(0, 99);
         if (r < 5) v = (r < 2) ? 0 : ((r < 4) ? 255 : int'($urandom_range(1, 254)));
         else begin
            v = int'(sp_r) + int'($urandom_range(0, 14)) - 7;
            if (v < 0) v = 0;
            if (v > 255) v = 255;
         end
         cyc($urandom_range(0, 99) < 45, 8'(v));
         exp_st = 2'(m_mode);
         n_tests++;
         if (status !== exp_st || heater_en !== (m_mode == 1) || cooler_en !== (m_mode == 2)) begin
            n_fail++;
            $display("FAIL random[%0d] status=%0d heater=%0d cooler=%0d expected %0d/%0d/%0d",
                     n, status, heater_en, cooler_en, exp_st, m_mode == 1, m_mode == 2);
         end
      end
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      temp_valid = 1'b0;
      temp_value = 8'd70;
      sp_r       = 8'd70;
      setpoint   = 8'd70;
      model_reset();
      #12;
      test_reset();
      test_heat();
      test_dwell();
      test_timeout();
      test_timeout_rescue();
      test_fault();
`ifdef TEMP_CTRL_FILTER_EN
      test_filter();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
